// File: rtl/csram_pkg.sv
// Shared types, constants and window decode for the clocked LC-3 code store.
package csram_pkg;

    localparam int unsigned CNT_W        = 4;
    localparam int unsigned BOOT_LEN     = 7;
    localparam logic [15:0] FILL_DEFAULT = 16'hffff;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Boot program placed at the bottom of the window when the image is enabled.
    localparam logic [15:0] BOOT_IMAGE [BOOT_LEN] = '{
        16'h9040, 16'h5060, 16'h9000, 16'h103f, 16'h0bfe, 16'hf025, 16'h0ff9
    };

    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned depth_log2);
        logic [31:0] mask;
        mask = ~((32'd1 << depth_log2) - 32'd1);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/csram_array.sv
// Single-port word storage: synchronous write, combinational read.
// CSRAM_BOOT_IMAGE_EN preloads the boot image; otherwise contents start unknown.
module csram_array
    import csram_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 8
`ifdef CSRAM_BOOT_IMAGE_EN
    ,
    parameter logic [DATA_W-1:0] FILL_DATA = DATA_W'(FILL_DEFAULT)
`endif
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] index,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata_c
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

`ifdef CSRAM_BOOT_IMAGE_EN
    logic [DATA_W-1:0] mem [DEPTH] = '{
        0: DATA_W'(BOOT_IMAGE[0]),
        1: DATA_W'(BOOT_IMAGE[1]),
        2: DATA_W'(BOOT_IMAGE[2]),
        3: DATA_W'(BOOT_IMAGE[3]),
        4: DATA_W'(BOOT_IMAGE[4]),
        5: DATA_W'(BOOT_IMAGE[5]),
        6: DATA_W'(BOOT_IMAGE[6]),
        default: FILL_DATA
    };
`else
    logic [DATA_W-1:0] mem [DEPTH];
`endif

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
    end

    assign rdata_c = mem[index];

endmodule

// File: rtl/csram_sync.sv
// Clocked code store on the LC-3 memory bus: ready/valid request, wait states, error flag.
// Define CSRAM_BOOT_IMAGE_EN to preload the boot image into storage.
module csram_sync
    import csram_pkg::*;
#(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       DEPTH_LOG2  = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(16'h3000),
    parameter int unsigned       WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] FILL_DATA   = DATA_W'(FILL_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_error
);

    localparam logic [CNT_W:0] WS_LIM = (CNT_W+1)'(WAIT_STATES);

    state_e              state;
    state_e              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W:0]      cnt_inc;
    logic                lat_write;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_data;
    logic                accept;
    logic                cur_write;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_data;
    logic                cur_hit;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_rdata;

    assign accept  = req_valid & req_ready;
    assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);

    // In IDLE the live bus is the current request; afterwards the latched copy is.
    always_comb begin
        cur_write = lat_write;
        cur_addr  = lat_addr;
        cur_data  = lat_data;
        if (state == IDLE) begin
            cur_write = req_write;
            cur_addr  = req_address;
            cur_data  = req_data;
        end
        cur_hit = in_window(32'(cur_addr), 32'(BASE_ADDR), DEPTH_LOG2);
    end

    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        unique case (state)
            IDLE:    if (accept) state_next = (WAIT_STATES != 0) ? WAIT : RESP;
            WAIT:    if (cnt_inc == WS_LIM) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Commit happens on the edge entering RESP so a reset in WAIT drops the write.
        if (state != RESP && state_next == RESP) begin
            mem_we = cur_write & cur_hit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
        end else begin
            state     <= state_next;
            req_ready <= (state_next == IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
        end else if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_address;
            lat_data  <= req_data;
        end
    end

    // Wait counter: cleared on entry to WAIT, saturates at the configured limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state != WAIT && state_next == WAIT) begin
            cnt <= '0;
        end else if (state == WAIT && {1'b0, cnt} != WS_LIM) begin
            cnt <= cnt_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= FILL_DATA;
            rsp_error <= 1'b0;
        end else begin
            rsp_valid <= (state == RESP);
            if (state == RESP) begin
                rsp_error <= ~cur_hit;
                rsp_data  <= cur_write ? cur_data : (cur_hit ? mem_rdata : FILL_DATA);
            end
        end
    end

    csram_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
`ifdef CSRAM_BOOT_IMAGE_EN
        ,
        .FILL_DATA  (FILL_DATA)
`endif
    ) u_array (
        .clk     (clk),
        .we      (mem_we),
        .index   (cur_addr[DEPTH_LOG2-1:0]),
        .wdata   (cur_data),
        .rdata_c (mem_rdata)
    );

endmodule

// File: tb/tb_csram_sync.sv
// Directed scoreboard bench for csram_sync at wait-state settings 0, 3 and 2.
module tb_csram_sync;

    localparam int unsigned NDUT = 3;
    localparam int unsigned WS_TAB [NDUT] = '{0, 3, 2};

    typedef struct {
        int          dev;
        logic [15:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n     [NDUT];
    logic        req_valid   [NDUT];
    logic        req_ready   [NDUT];
    logic        req_write   [NDUT];
    logic [15:0] req_address [NDUT];
    logic [15:0] req_data    [NDUT];
    logic        rsp_valid   [NDUT];
    logic [15:0] rsp_data    [NDUT];
    logic        rsp_error   [NDUT];

    logic [15:0] boot [7] = '{16'h9040, 16'h5060, 16'h9000, 16'h103f, 16'h0bfe, 16'hf025, 16'h0ff9};

    exp_t sb [$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        csram_sync #(
            .WAIT_STATES (WS_TAB[g])
        ) u_dut (
            .clk         (clk),
            .reset_n     (reset_n[g]),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_write   (req_write[g]),
            .req_address (req_address[g]),
            .req_data    (req_data[g]),
            .rsp_valid   (rsp_valid[g]),
            .rsp_data    (rsp_data[g]),
            .rsp_error   (rsp_error[g])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < NDUT; d++) begin
            if (rsp_valid[d] === 1'b1) begin
                chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp_dev",   32'(d),            32'(e.dev));
                    chk("rsp_cycle", 32'(cyc),          32'(e.due));
                    chk("rsp_data",  32'(rsp_data[d]),  32'(e.data));
                    chk("rsp_error", 32'(rsp_error[d]), 32'(e.err));
                end
            end
        end
    end

    task automatic do_req(input int d, input logic wr, input logic [15:0] a, input logic [15:0] dat,
                          input logic [15:0] exp_d, input logic exp_e, input bit push, output int acc);
        int waited;
        @(negedge clk);
        req_valid[d]   = 1'b1;
        req_write[d]   = wr;
        req_address[d] = a;
        req_data[d]    = dat;
        waited = 0;
        while (req_ready[d] !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_in_time", 32'(waited < 50), 32'd1);
        acc = cyc + 1;
        if (push) sb.push_back('{dev: d, data: exp_d, err: exp_e, due: acc + int'(WS_TAB[d]) + 1});
        @(posedge clk);
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int a0, a1, a2;
        for (int d = 0; d < NDUT; d++) begin
            reset_n[d]     = 1'b0;
            req_valid[d]   = 1'b0;
            req_write[d]   = 1'b0;
            req_address[d] = 16'h0000;
            req_data[d]    = 16'h0000;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk("reset_ready",     32'(req_ready[d]), 32'd1);
            chk("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("reset_rsp_data",  32'(rsp_data[d]),  32'h0000ffff);
            chk("reset_rsp_error", 32'(rsp_error[d]), 32'd0);
        end
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) reset_n[d] = 1'b1;

`ifndef CSRAM_BOOT_IMAGE_EN
        // Without the boot image, load the same words through the bus first.
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 7; i++) begin
                do_req(d, 1'b1, 16'h3000 + 16'(i), boot[i], boot[i], 1'b0, 1'b1, a0);
            end
            idle(d);
        end
        drain();
`endif

        // Zero wait states: boot read, write-then-read, window edges.
        do_req(0, 1'b0, 16'h3000, 16'h0000, 16'h9040, 1'b0, 1'b1, a0);
        idle(0);
        drain();
        do_req(0, 1'b1, 16'h3010, 16'hbeef, 16'hbeef, 1'b0, 1'b1, a1);
        do_req(0, 1'b0, 16'h3010, 16'h0000, 16'hbeef, 1'b0, 1'b1, a2);
        chk("b2b_interval_ws0", 32'(a2 - a1), 32'd2);
        do_req(0, 1'b0, 16'h2fff, 16'h0000, 16'hffff, 1'b1, 1'b1, a0);
        do_req(0, 1'b0, 16'h3100, 16'h0000, 16'hffff, 1'b1, 1'b1, a0);
        do_req(0, 1'b1, 16'h4000, 16'h1234, 16'h1234, 1'b1, 1'b1, a0);
        do_req(0, 1'b0, 16'h3000, 16'h0000, 16'h9040, 1'b0, 1'b1, a0);
        do_req(0, 1'b1, 16'h30ff, 16'h5a5a, 16'h5a5a, 1'b0, 1'b1, a0);
        do_req(0, 1'b0, 16'h30ff, 16'h0000, 16'h5a5a, 1'b0, 1'b1, a0);
        idle(0);
        drain();

        // Three wait states with valid held high: one accept every five cycles.
        do_req(1, 1'b0, 16'h3000, 16'h0000, 16'h9040, 1'b0, 1'b1, a0);
        do_req(1, 1'b0, 16'h3001, 16'h0000, 16'h5060, 1'b0, 1'b1, a1);
        do_req(1, 1'b0, 16'h3002, 16'h0000, 16'h9000, 1'b0, 1'b1, a2);
        chk("b2b_interval_ws3_a", 32'(a1 - a0), 32'd5);
        chk("b2b_interval_ws3_b", 32'(a2 - a1), 32'd5);
        idle(1);
        drain();

        // Reset during WAIT aborts the write and produces no response.
        do_req(2, 1'b1, 16'h3005, 16'h0000, 16'h0000, 1'b0, 1'b0, a0);
        @(negedge clk);
        chk("ready_low_in_wait", 32'(req_ready[2]), 32'd0);
        req_valid[2] = 1'b0;
        reset_n[2]   = 1'b0;
        #1;
        chk("abort_ready",     32'(req_ready[2]), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid[2]), 32'd0);
        repeat (2) @(negedge clk);
        reset_n[2] = 1'b1;
        repeat (8) @(negedge clk);
        do_req(2, 1'b0, 16'h3005, 16'h0000, 16'hf025, 1'b0, 1'b1, a0);
        idle(2);
        drain();

        // Address changes during WAIT must not affect the latched request.
        do_req(2, 1'b0, 16'h3006, 16'h0000, 16'h0ff9, 1'b0, 1'b1, a0);
        @(negedge clk);
        req_valid[2]   = 1'b0;
        req_write[2]   = 1'b1;
        req_address[2] = 16'h3000;
        req_data[2]    = 16'hdead;
        drain();
        do_req(2, 1'b0, 16'h3000, 16'h0000, 16'h9040, 1'b0, 1'b1, a0);
        idle(2);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
